// File: rtl/countdown_timer.sv
// countdown_timer: prescaled, loadable down-counter with start/pause/resume,
// one-shot or auto-reload modes, a tick pulse per prescaler period and an
// expiry pulse when the count reaches zero.
module countdown_timer #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned TICK_FREQ = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             mode,
    output logic             tick,
    output logic             expired,
    output logic [CNT_W-1:0] remaining,
    output logic             running,
    output logic             done
);

    localparam int unsigned DIV = CLK_FREQ / TICK_FREQ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    prescale_q, prescale_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             tick_q, tick_d;
    logic             expired_q, expired_d;

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            prescale_q  <= '0;
            remaining_q <= '0;
            reload_q    <= '0;
            tick_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescale_q  <= prescale_d;
            remaining_q <= remaining_d;
            reload_q    <= reload_d;
            tick_q      <= tick_d;
            expired_q   <= expired_d;
        end
    end

    // Next-state logic; priority is load > pause > start > terminal count.
    always_comb begin
        state_d     = state_q;
        prescale_d  = prescale_q;
        remaining_d = remaining_q;
        reload_d    = reload_q;
        tick_d      = 1'b0;
        expired_d   = 1'b0;

        if (load) begin
            remaining_d = load_val;
            reload_d    = load_val;
            prescale_d  = '0;
            state_d     = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && remaining_q != CNT_ZERO) begin
                        state_d    = StRun;
                        prescale_d = '0;
                    end
                end
                StRun: begin
                    if (pause) begin
                        // Prescaler phase is held so resume loses no time.
                        state_d = StPaused;
                    end else if (prescale_q == PRE_LAST) begin
                        prescale_d = '0;
                        tick_d     = 1'b1;
                        if (remaining_q == CNT_ONE) begin
                            expired_d = 1'b1;
                            if (mode) begin
                                remaining_d = reload_q;
                            end else begin
                                remaining_d = CNT_ZERO;
                                state_d     = StDone;
                            end
                        end else begin
                            remaining_d = remaining_q - CNT_ONE;
                        end
                    end else begin
                        prescale_d = prescale_q + PW'(1);
                    end
                end
                StPaused: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    if (start && reload_q != CNT_ZERO) begin
                        remaining_d = reload_q;
                        prescale_d  = '0;
                        state_d     = StRun;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign tick      = tick_q;
    assign expired   = expired_q;
    assign remaining = remaining_q;
    assign running   = (state_q == StRun);
    assign done      = (state_q == StDone);

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Parametrised seconds-style countdown timer for the BombSquad game core, generalising the fixed one-second pulse generator. An internal prescaler divides the system clock down to a tick rate. A loadable down-counter, decremented on each tick, provides start/pause/resume control, one-shot or auto-reload modes, a remaining-count output for the display path, and an expiry pulse for the game FSM.

## Interface
- CLK_FREQ, 50000000, input clock frequency in Hz
- TICK_FREQ, 1, tick rate in Hz; DIV = CLK_FREQ/TICK_FREQ must be an integer ≥ 2
- CNT_W, 8, width of the countdown value
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- load  in  1  load load_val into count and reload register
- load_val  in  CNT_W  value sampled when load=1
- start  in  1  start / resume / restart
- pause  in  1  freeze countdown while running
- mode  in  1  0 = one-shot, 1 = auto-reload; sampled at each expiry
- tick  out  1  one-cycle pulse per elapsed tick period while running
- expired  out  1  one-cycle pulse when count reaches 0
- remaining  out  CNT_W  current count
- running  out  1  high in RUN state
- done  out  1  high in DONE state

## Operation
- The prescaler has width clog2(DIV) and counts 0..DIV-1, advancing only in RUN. The terminal condition is prescale == DIV-1.
- The FSM has four states: IDLE, RUN, PAUSED, DONE.
- Reset state:
  - state = IDLE
  - prescale = 0, remaining = 0, reload = 0
  - tick = expired = running = done = 0
- Priority per cycle: load > pause > start > terminal-count.
- load (any state):
  - remaining ← load_val, reload ← load_val
  - prescale ← 0, state ← IDLE
  - No tick or expired pulse that cycle, even if the prescaler was terminal.
- IDLE:
  - start with remaining ≠ 0 → RUN, prescale ← 0.
  - start with remaining = 0 is ignored.
- RUN:
  - pause → PAUSED, prescale held, no tick that cycle.
  - On the terminal condition: prescale ← 0, tick pulses, remaining ← remaining-1.
  - If remaining was 1: expired pulses.
    - mode = 0: remaining ← 0, state → DONE.
    - mode = 1: remaining ← reload, stay in RUN.
  - start is ignored.
- PAUSED:
  - start → RUN, resuming from the held prescale value (no phase loss).
  - pause is ignored.
- DONE:
  - start with reload ≠ 0 → remaining ← reload, prescale ← 0, RUN.
  - start with reload = 0 is ignored.
- Arithmetic: remaining never wraps below 0. A reload of 0 in mode 1 cannot occur, because RUN is unreachable with remaining = 0.

## Timing
- All outputs are registered; no combinational input-to-output path.
- running/done reflect the state after the edge that samples the command; latency is 1 cycle.
- First tick: asserted DIV cycles after the edge that samples start (prescale 0 → DIV-1, then terminal).
- Later ticks occur every DIV cycles while in RUN.
- expired is coincident with the tick that takes remaining from 1 to 0; this is N·DIV cycles after start for load_val = N, with no pauses.
- In DONE after a mode-0 expiry, remaining shows 0 and done rises in the same cycle as expired.
- Pause/resume: the total RUN cycles to expiry stay N·DIV regardless of how many pauses occur.
- Asynchronous reset mid-count: all outputs clear without waiting for clk. After deassertion the block sits in IDLE with remaining = 0 until load.

## Test plan
Bench parameters: CLK_FREQ=10, TICK_FREQ=1 (DIV=10), CNT_W=8.
- Reset, then load 3, then start:
  - ticks at 10, 20 and 30 cycles after start.
  - remaining reads 2, 1, 0.
  - expired and done rise at cycle 30; running falls at cycle 30.
  - No further ticks.
- mode=1, load 2, start:
  - expired at cycles 20 and 40.
  - remaining sequence is 1, 0→2 (reload on the expiry cycle), 1, 2…
  - running stays 1 throughout.
- load 2, start, pause at cycle 5 for 7 cycles, then start:
  - first tick occurs 5 cycles after resume.
  - expiry at 20 RUN cycles total.
- Simultaneous events:
  - load 5 with start in the same cycle → IDLE with remaining 5.
  - pause asserted on the terminal prescale cycle → no tick, PAUSED.
- Edge cases:
  - start in IDLE with remaining 0 → no state change.
  - start in DONE after load 4 → remaining 4, RUN again.
- reset asserted asynchronously between clock edges mid-count:
  - outputs are 0 before the next edge.
  - post-reset start is ignored until load.
